// File: rtl/fp16_acc_pkg.sv
// FP16 product accumulator: shared field widths, fixed-point scaling and FSM states.
package fp16_acc_pkg;

    localparam int unsigned EXP_BITS  = 5;
    localparam int unsigned MAN_BITS  = 10;
    localparam int unsigned BIAS      = 15;
    localparam int unsigned FRAC_BITS = 24;
    localparam int unsigned MAG_BITS  = 41;
    localparam int unsigned FP_W      = 1 + EXP_BITS + MAN_BITS;

    localparam logic [FP_W-1:0] MAX_FINITE = 16'h7BFF;

    typedef enum logic [1:0] {
        ACCUM,
        DRAIN,
        NORM,
        OUT
    } state_t;

endpackage

// File: rtl/lzc.sv
// Leading/trailing zero counter. MODE=1 counts leading zeros, MODE=0 trailing zeros.
// An all-zero input reports WIDTH and raises o_zero_c.
module lzc #(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned MODE  = 1,
    localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] i_data,
    output logic [CNT_W-1:0] o_cnt_c,
    output logic             o_zero_c
);

    // Priority scan: the last hit in scan order is the bit nearest the counted end.
    always_comb begin
        o_cnt_c = CNT_W'(WIDTH);
        if (MODE == 1) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (i_data[i]) o_cnt_c = CNT_W'(WIDTH - 1 - i);
            end
        end else begin
            for (int unsigned i = WIDTH; i > 0; i--) begin
                if (i_data[i-1]) o_cnt_c = CNT_W'(i - 1);
            end
        end
    end

    assign o_zero_c = ~|i_data;

endmodule

// File: rtl/fp16_prod_accum.sv
// Streaming FP16 product accumulator: exact fixed-point sum (24 fraction bits) of a
// packet of FP16 products, normalised back to FP16 on the last beat.
// Optional macro FP16_ACC_RNE_EN: round-to-nearest-even packing instead of truncation.
module fp16_prod_accum
    import fp16_acc_pkg::*;
#(
    parameter int unsigned MAX_TERMS = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [15:0] in_data_i,
    input  logic        in_last_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [15:0] out_data_o,
    output logic        out_overflow_o,
    output logic        busy_o
);

    localparam int unsigned GUARD     = $clog2(MAX_TERMS);
    localparam int unsigned ACC_WIDTH = 42 + GUARD;
    localparam int unsigned CNT_W     = $clog2(MAX_TERMS + 1);
    localparam int unsigned LZ_W      = $clog2(ACC_WIDTH + 1);

    state_t                 r_state;
    logic                   r_in_ready;
    logic                   r_busy;
    logic                   r_out_valid;
    logic [FP_W-1:0]        r_out_data;
    logic                   r_ovf;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_term_vld;
    logic [ACC_WIDTH-1:0]   r_term;
    logic [ACC_WIDTH-1:0]   r_acc;

    logic                   w_in_fire;
    logic                   w_out_fire;
    logic [EXP_BITS-1:0]    w_exp_in;
    logic [MAN_BITS:0]      w_man_in;
    logic [EXP_BITS-1:0]    w_shift;
    logic [MAG_BITS-1:0]    w_mag_in;
    logic [ACC_WIDTH-1:0]   w_term;

    logic                   w_sign;
    logic [ACC_WIDTH-1:0]   w_mag;
    logic [LZ_W-1:0]        w_lz;
    logic                   w_zero;
    logic [LZ_W-1:0]        w_p;
    logic [ACC_WIDTH-1:0]   w_norm;
    logic [EXP_BITS-1:0]    w_exp_n;
    logic [MAN_BITS-1:0]    w_frac_n;
    logic [FP_W-1:0]        w_pack;
    logic                   w_unused_bits;

    assign w_in_fire  = in_valid_i && r_in_ready;
    assign w_out_fire = r_out_valid && out_ready_i;

    // Alignment: place the significand at its binary weight in units of 2^-24.
    assign w_exp_in = in_data_i[FP_W-2 -: EXP_BITS];
    assign w_man_in = {(w_exp_in != '0), in_data_i[MAN_BITS-1:0]};
    assign w_shift  = (w_exp_in == '0) ? '0 : w_exp_in - EXP_BITS'(1);
    assign w_mag_in = MAG_BITS'(w_man_in) << w_shift;
    assign w_term   = in_data_i[FP_W-1] ? (ACC_WIDTH'(0) - ACC_WIDTH'(w_mag_in))
                                        : ACC_WIDTH'(w_mag_in);

    // Magnitude of the sum and its leading-one position.
    assign w_sign = r_acc[ACC_WIDTH-1];
    assign w_mag  = w_sign ? (ACC_WIDTH'(0) - r_acc) : r_acc;

    lzc #(
        .WIDTH (ACC_WIDTH),
        .MODE  (1)
    ) u_lzc (
        .i_data   (w_mag),
        .o_cnt_c  (w_lz),
        .o_zero_c (w_zero)
    );

    assign w_p     = LZ_W'(ACC_WIDTH - 1) - w_lz;
    assign w_norm  = w_mag << w_lz;
    assign w_exp_n = EXP_BITS'(w_p - LZ_W'(FRAC_BITS - BIAS));
    assign w_frac_n = w_norm[ACC_WIDTH-2 -: MAN_BITS];

    // Packing: zero, subnormal (exact), normal (truncate or RNE), saturate.
`ifdef FP16_ACC_RNE_EN
    logic            w_guard;
    logic            w_sticky;
    logic            w_inc;
    logic [FP_W-1:0] w_rnd;

    assign w_guard       = w_norm[ACC_WIDTH-2-MAN_BITS];
    assign w_sticky      = |w_norm[ACC_WIDTH-3-MAN_BITS:0];
    assign w_inc         = w_guard & (w_sticky | w_frac_n[0]);
    assign w_rnd         = {1'b0, w_exp_n, w_frac_n} + FP_W'(w_inc);
    assign w_unused_bits = w_norm[ACC_WIDTH-1];

    always_comb begin
        w_pack = '0;
        if (w_zero) begin
            w_pack = '0;
        end else if (w_p < LZ_W'(MAN_BITS)) begin
            w_pack = {w_sign, {EXP_BITS{1'b0}}, w_mag[MAN_BITS-1:0]};
        end else if (w_p >= LZ_W'(MAG_BITS - 1)) begin
            w_pack = {w_sign, MAX_FINITE[FP_W-2:0]};
        end else if (w_rnd[FP_W-2 -: EXP_BITS] == '1) begin
            w_pack = {w_sign, MAX_FINITE[FP_W-2:0]};
        end else begin
            w_pack = {w_sign, w_rnd[FP_W-2:0]};
        end
    end
`else
    assign w_unused_bits = ^{w_norm[ACC_WIDTH-1], w_norm[ACC_WIDTH-2-MAN_BITS:0]};

    always_comb begin
        w_pack = '0;
        if (w_zero) begin
            w_pack = '0;
        end else if (w_p < LZ_W'(MAN_BITS)) begin
            w_pack = {w_sign, {EXP_BITS{1'b0}}, w_mag[MAN_BITS-1:0]};
        end else if (w_p >= LZ_W'(MAG_BITS - 1)) begin
            w_pack = {w_sign, MAX_FINITE[FP_W-2:0]};
        end else begin
            w_pack = {w_sign, w_exp_n, w_frac_n};
        end
    end
`endif

    // Datapath registers and packet FSM; the result clear on handshake overrides accumulation.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ACCUM;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_ovf       <= 1'b0;
            r_cnt       <= '0;
            r_term_vld  <= 1'b0;
            r_term      <= '0;
            r_acc       <= '0;
        end else begin
            r_term_vld <= w_in_fire;
            if (w_in_fire) r_term <= w_term;
            if (r_term_vld) r_acc <= r_acc + r_term;

            case (r_state)
                ACCUM: begin
                    if (w_in_fire) begin
                        r_busy <= 1'b1;
                        if (r_cnt == CNT_W'(MAX_TERMS)) r_ovf <= 1'b1;
                        else                            r_cnt <= r_cnt + CNT_W'(1);
                        if (in_last_i) begin
                            r_state    <= DRAIN;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    r_state <= NORM;
                end
                NORM: begin
                    r_out_data  <= w_pack;
                    r_out_valid <= 1'b1;
                    r_state     <= OUT;
                end
                OUT: begin
                    if (w_out_fire) begin
                        r_out_valid <= 1'b0;
                        r_acc       <= '0;
                        r_cnt       <= '0;
                        r_ovf       <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ACCUM;
                    end
                end
                default: begin
                    r_state <= ACCUM;
                end
            endcase
        end
    end

    assign in_ready_o     = r_in_ready;
    assign busy_o         = r_busy;
    assign out_valid_o    = r_out_valid;
    assign out_data_o     = r_out_data;
    assign out_overflow_o = r_ovf;

endmodule

// File: tb/tb_fp16_prod_accum.sv
// Scoreboard bench for fp16_prod_accum: stimulus pushes expected results, a monitor
// pops and compares on each output handshake, and also checks latency and hold behaviour.
module tb_fp16_prod_accum;

    localparam int MAX_TERMS = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic        out_ovf;
    logic        busy;

    typedef struct {
        logic [15:0] data;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   t_last   = -100;
    bit   rdy_rand  = 1'b0;
    bit   rdy_fixed = 1'b1;

    fp16_prod_accum dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .in_data_i      (in_data),
        .in_last_i      (in_last),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .out_data_o     (out_data),
        .out_overflow_o (out_ovf),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer back-pressure: fixed level or random per cycle.
    always @(posedge clk) begin
        #1;
        out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic finish_sim();
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    endtask

    // Reference: exact sum in units of 2^-24, then FP16 conversion by plain arithmetic.
    function automatic logic [15:0] ref_sum(input logic [15:0] b[$]);
        longint s = 0;
        longint m, mag, q, rem, half;
        int     e, p, ex;
        logic   sg;
        foreach (b[i]) begin
            e = int'(b[i][14:10]);
            m = longint'(b[i][9:0]) + ((e != 0) ? 64'd1024 : 64'd0);
            if (e == 0) e = 1;
            // value = m * 2^(e-15-10); scaled by 2^24
            m = m <<< (e - 15 - 10 + 24);
            s = b[i][15] ? s - m : s + m;
        end
        sg  = (s < 0);
        mag = sg ? -s : s;
        if (mag == 0) return 16'h0000;
        p = 0;
        while ((mag >> (p + 1)) != 0) p++;
        if (p < 10) return {sg, 5'd0, mag[9:0]};
        if (p >= 40) return {sg, 15'h7BFF};
        ex = p - 9;
        q  = mag >> (p - 10);
`ifdef FP16_ACC_RNE_EN
        if (p > 10) begin
            rem  = mag - (q << (p - 10));
            half = longint'(1) << (p - 11);
            if (rem > half || (rem == half && q[0])) q++;
        end
        if (q == 2048) begin
            q = 1024;
            ex++;
        end
        if (ex >= 31) return {sg, 15'h7BFF};
`else
        rem  = 0;
        half = 0;
`endif
        return {sg, 5'(ex), 10'(q - 1024)};
    endfunction

    // Drive current beat until accepted; a stuck in_ready ends the run with a FAIL.
    task automatic wait_accept();
        int budget = 0;
        while (!in_ready) begin
            @(posedge clk); #1;
            budget++;
            if (budget > 60) begin
                n_checks++;
                n_fail++;
                $display("FAIL accept_timeout: in_ready stayed %b expected 1", in_ready);
                finish_sim();
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic send_pkt(input logic [15:0] beats[$], input bit gaps,
                            input bit use_const, input logic [15:0] cexp);
        exp_t e;
        for (int i = 0; i < beats.size(); i++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    in_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            in_valid = 1'b1;
            in_data  = beats[i];
            in_last  = (i == beats.size() - 1);
            wait_accept();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        e.data = use_const ? cexp : ref_sum(beats);
        e.ovf  = (beats.size() > MAX_TERMS);
        sb.push_back(e);
    endtask

    task automatic run_fixed(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                             input int n, input logic [15:0] cexp);
        logic [15:0] pk[$];
        if (n >= 1) pk.push_back(a);
        if (n >= 2) pk.push_back(b);
        if (n >= 3) pk.push_back(c);
        send_pkt(pk, 1'b0, 1'b1, cexp);
    endtask

    task automatic drain_sb();
        int budget = 0;
        while (sb.size() != 0) begin
            @(posedge clk); #1;
            budget++;
            if (budget > 300) begin
                n_checks++;
                n_fail++;
                $display("FAIL drain_timeout: %0d results outstanding expected 0", sb.size());
                finish_sim();
            end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: compare on output handshake; check latency, hold-while-stalled, ready gating.
    logic        pv = 1'b0, pr = 1'b0, phs = 1'b0, po = 1'b0;
    logic [15:0] pd = '0;
    always @(negedge clk) begin
        if (rst) begin
            pv = 1'b0; pr = 1'b0; phs = 1'b0;
            t_last = -100;
        end else begin
            if (phs) begin
                chk("in_ready_after_handshake", 32'(in_ready), 32'd1);
                chk("busy_after_handshake", 32'(busy), 32'd0);
            end
            if (out_valid) begin
                chk("in_ready_low_while_valid", 32'(in_ready), 32'd0);
                if (!pv) chk("latency_cycles", 32'(cyc - t_last), 32'd3);
                else if (!pr) begin
                    chk("hold_data", 32'(out_data), 32'(pd));
                    chk("hold_overflow", 32'(out_ovf), 32'(po));
                end
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_result: got %h expected none", out_data);
                    end else begin
                        mon_e = sb.pop_front();
                        chk("result", 32'(out_data), 32'(mon_e.data));
                        chk("overflow", 32'(out_ovf), 32'(mon_e.ovf));
                    end
                end
            end
            if (in_valid && in_ready && in_last) t_last = cyc;
            phs = out_valid && out_ready;
            pv  = out_valid;
            pr  = out_ready;
            pd  = out_data;
            po  = out_ovf;
        end
    end

    initial begin
        logic [15:0] pk[$];
        int          budget;
        int          emax;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data", 32'(out_data), 32'd0);
        chk("reset_overflow", 32'(out_ovf), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed arithmetic cases with hand-computed results.
        run_fixed(16'h3C00, 16'h4000, 16'h0000, 2, 16'h4200);
        run_fixed(16'h3C00, 16'hBC00, 16'h0000, 2, 16'h0000);
        run_fixed(16'h0001, 16'h0001, 16'h0001, 3, 16'h0003);
        run_fixed(16'h7BFF, 16'h7BFF, 16'h0000, 2, 16'h7BFF);
        run_fixed(16'hFBFF, 16'hFBFF, 16'h0000, 2, 16'hFBFF);
`ifdef FP16_ACC_RNE_EN
        run_fixed(16'h3C01, 16'h1000, 16'h0000, 2, 16'h3C02);
`else
        run_fixed(16'h3C01, 16'h1000, 16'h0000, 2, 16'h3C01);
`endif
        run_fixed(16'hC500, 16'h0000, 16'h0000, 1, 16'hC500);
        drain_sb();

        // Consumer stall: result must hold, input side blocked.
        rdy_fixed = 1'b0;
        @(posedge clk); #1;
        run_fixed(16'h3C00, 16'h3C00, 16'h0000, 2, 16'h4000);
        budget = 0;
        while (!out_valid) begin
            @(posedge clk); #1;
            budget++;
            if (budget > 10) begin
                n_checks++;
                n_fail++;
                $display("FAIL stall_valid_timeout: out_valid %b expected 1", out_valid);
                finish_sim();
            end
        end
        repeat (5) begin
            @(posedge clk); #1;
            chk("stall_data", 32'(out_data), 32'h4000);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_busy", 32'(busy), 32'd1);
        end
        rdy_fixed = 1'b1;
        drain_sb();

        // Reset in the middle of a packet discards the partial sum.
        in_valid = 1'b1; in_data = 16'h3C00; in_last = 1'b0;
        wait_accept();
        in_data = 16'h4000;
        wait_accept();
        in_valid = 1'b0;
        chk("busy_mid_packet", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_data", 32'(out_data), 32'd0);
        chk("midrst_overflow", 32'(out_ovf), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        run_fixed(16'h4400, 16'h0000, 16'h0000, 1, 16'h4400);
        drain_sb();

        // Overflow: MAX_TERMS+1 zero beats, then a normal packet clears the flag.
        pk.delete();
        for (int i = 0; i < MAX_TERMS + 1; i++) pk.push_back(16'h0000);
        send_pkt(pk, 1'b0, 1'b0, 16'h0000);
        drain_sb();
        run_fixed(16'h3C00, 16'h0000, 16'h0000, 1, 16'h3C00);
        drain_sb();

        // Randomised packets against the reference model with random back-pressure.
        rdy_rand = 1'b1;
        for (int k = 0; k < 40; k++) begin
            pk.delete();
            emax = $urandom_range(3, 31);
            for (int i = 0; i < int'($urandom_range(1, 8)); i++) begin
                pk.push_back({1'($urandom_range(0, 1)), 5'($urandom_range(0, emax)),
                              10'($urandom_range(0, 1023))});
            end
            send_pkt(pk, 1'b1, 1'b0, 16'h0000);
        end
        drain_sb();
        rdy_rand = 1'b0;

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        finish_sim();
    end

endmodule
